// File: rtl/voice_allocator_if.sv
// Note-event handshake from the MIDI decoder into the voice allocator.
interface voice_allocator_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_is_on;
  logic [7:0] ev_key;
  logic [7:0] ev_vel;

  modport master (output ev_valid, ev_is_on, ev_key, ev_vel, input ev_ready);
  modport slave  (input ev_valid, ev_is_on, ev_key, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Maps MIDI note events onto synth voices with a one-voice-per-clock scan,
// stealing the oldest releasing/held voice when no idle voice exists.
module voice_allocator #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3,
  parameter int unsigned AGE_W   = 8
) (
  input  logic               OSC_CLK,
  input  logic               iRST,
  voice_allocator_if.slave   ev,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               steal
);

  localparam int unsigned         KEY_W    = 8;
  localparam logic [AGE_W-1:0]    AGE_MAX  = '1;
  localparam logic [V_WIDTH-1:0]  LAST_IDX = V_WIDTH'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t             state, state_nx;
  logic [KEY_W-1:0]   key_tab [VOICES];
  logic [AGE_W-1:0]   age     [VOICES];
  logic               lat_on;
  logic [KEY_W-1:0]   lat_key;
  logic [KEY_W-1:0]   lat_vel;
  logic [V_WIDTH-1:0] idx;
  logic [V_WIDTH-1:0] best_idx;
  logic [1:0]         best_cls;
  logic               best_found;

  logic               last;
  logic               hit;
  logic               better;
  logic [1:0]         cls;
  logic [V_WIDTH-1:0] sel_idx;
  logic [1:0]         sel_cls;
  logic               sel_found;

  assign ev.ev_ready = (state == IDLE) && !iRST;

  // State register
  always_ff @(posedge OSC_CLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state plus the running best-candidate selection for the scanned voice
  always_comb begin
    state_nx  = state;
    last      = (idx == LAST_IDX);
    hit       = keys_on[idx] && (key_tab[idx] == lat_key);
    cls       = 2'd0;
    better    = 1'b0;
    sel_idx   = best_idx;
    sel_cls   = best_cls;
    sel_found = best_found;

    if (hit)                cls = 2'd3;
    else if (!keys_on[idx]) cls = voice_free[idx] ? 2'd2 : 2'd1;

    // Only steal classes (0/1) compete on age; class 2/3 keep the first found
    if (lat_on)
      better = !best_found || (cls > best_cls) ||
               ((cls == best_cls) && !cls[1] && (age[idx] > age[best_idx]));
    else
      better = hit && !best_found;

    if (better) begin
      sel_idx   = idx;
      sel_cls   = cls;
      sel_found = 1'b1;
    end

    case (state)
      IDLE:    if (ev.ev_valid) state_nx = SCAN;
      SCAN:    if (last) state_nx = ISSUE;
      ISSUE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Event latch, scan bookkeeping and voice table / output updates
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      keys_on     <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      steal       <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      lat_on      <= 1'b0;
      lat_key     <= '0;
      lat_vel     <= '0;
      idx         <= '0;
      best_idx    <= '0;
      best_cls    <= '0;
      best_found  <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        key_tab[v] <= '0;
        age[v]     <= '0;
      end
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      steal    <= 1'b0;
      case (state)
        IDLE: begin
          if (ev.ev_valid) begin
            // Velocity-0 note-on is a note-off by MIDI convention
            lat_on     <= ev.ev_is_on && (ev.ev_vel != 8'd0);
            lat_key    <= ev.ev_key;
            lat_vel    <= ev.ev_vel;
            idx        <= '0;
            best_idx   <= '0;
            best_cls   <= '0;
            best_found <= 1'b0;
          end
        end
        SCAN: begin
          idx        <= idx + V_WIDTH'(1);
          best_idx   <= sel_idx;
          best_cls   <= sel_cls;
          best_found <= sel_found;
          if (last) begin
            if (lat_on) begin
              keys_on[sel_idx] <= 1'b1;
              key_tab[sel_idx] <= lat_key;
              for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == sel_idx)  age[v] <= '0;
                else if (age[v] != AGE_MAX) age[v] <= age[v] + AGE_W'(1);
              end
              cur_key_adr <= sel_idx;
              cur_key_val <= lat_key;
              cur_vel_on  <= lat_vel;
              note_on     <= 1'b1;
              steal       <= !sel_cls[1];
            end else if (sel_found) begin
              keys_on[sel_idx] <= 1'b0;
              cur_key_adr      <= sel_idx;
              cur_key_val      <= lat_key;
              cur_vel_off      <= lat_vel;
              note_off         <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: each event pushes its expected issue
// record, which is popped and compared when the DUT pulses.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] voice_free = 8'hFF;
  logic [7:0] keys_on;
  logic       note_on, note_off, steal;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         kind;   // 0 = dropped, 1 = note_on, 2 = note_off
    logic [2:0] adr;
    logic [7:0] key;
    logic [7:0] vel;
    logic       stl;
    logic [7:0] keys;
  } exp_t;

  exp_t sbq[$];

  voice_allocator_if ev_if ();

  voice_allocator #(.VOICES(8), .V_WIDTH(3), .AGE_W(8)) dut (
    .OSC_CLK    (clk),
    .iRST       (rst),
    .ev         (ev_if.slave),
    .voice_free (voice_free),
    .keys_on    (keys_on),
    .note_on    (note_on),
    .note_off   (note_off),
    .cur_key_adr(cur_key_adr),
    .cur_key_val(cur_key_val),
    .cur_vel_on (cur_vel_on),
    .cur_vel_off(cur_vel_off),
    .steal      (steal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one event, push its expectation, then watch 20 cycles for the issue
  task automatic run_event(input logic is_on, input logic [7:0] key, input logic [7:0] vel,
                           input int kind, input logic [2:0] adr, input logic stl,
                           input logic [7:0] keys, input string name);
    exp_t e, got;
    int   n, pulse_cyc, rdy_cyc, pulse_hi;
    e.kind = kind; e.adr = adr; e.key = key; e.vel = vel; e.stl = stl; e.keys = keys;
    @(negedge clk);
    ev_if.ev_valid = 1'b1; ev_if.ev_is_on = is_on; ev_if.ev_key = key; ev_if.ev_vel = vel;
    n = 0;
    while (ev_if.ev_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (n >= 40) $display("FAIL %s accept: ev_ready never high", name); else passed++;
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    pulse_cyc = 0; rdy_cyc = 0; pulse_hi = 0;
    for (int c = 1; c <= 20; c++) begin
      if (note_on || note_off) pulse_hi++;
      if ((note_on || note_off) && pulse_cyc == 0) begin
        pulse_cyc = c;
        got = sbq.pop_front();
        total++;
        if (c !== 9) $display("FAIL %s latency: got %0d want 9", name, c); else passed++;
        total++;
        if (int'({note_off, note_on}) !== got.kind)
          $display("FAIL %s kind: got %0d want %0d", name, int'({note_off, note_on}), got.kind);
        else passed++;
        total++;
        if (cur_key_adr !== got.adr) $display("FAIL %s adr: got %0d want %0d", name, cur_key_adr, got.adr);
        else passed++;
        total++;
        if (cur_key_val !== got.key) $display("FAIL %s key: got %0d want %0d", name, cur_key_val, got.key);
        else passed++;
        total++;
        if ((note_on ? cur_vel_on : cur_vel_off) !== got.vel)
          $display("FAIL %s vel: got %0d want %0d", name, note_on ? cur_vel_on : cur_vel_off, got.vel);
        else passed++;
        total++;
        if (steal !== got.stl) $display("FAIL %s steal: got %b want %b", name, steal, got.stl);
        else passed++;
        total++;
        if (keys_on !== got.keys) $display("FAIL %s keys_on: got %h want %h", name, keys_on, got.keys);
        else passed++;
      end
      if (ev_if.ev_ready === 1'b1 && rdy_cyc == 0) rdy_cyc = c;
      @(negedge clk);
    end
    if (pulse_cyc == 0) begin
      got = sbq.pop_front();
      total++;
      if (got.kind != 0) $display("FAIL %s missing pulse: got none want kind %0d", name, got.kind);
      else passed++;
    end
    total++;
    if (pulse_hi !== (kind != 0 ? 1 : 0))
      $display("FAIL %s pulse width: got %0d want %0d", name, pulse_hi, (kind != 0 ? 1 : 0));
    else passed++;
    total++;
    if (rdy_cyc !== 10) $display("FAIL %s ready return: got %0d want 10", name, rdy_cyc);
    else passed++;
  endtask

  // Note-ons for 60..67 with no idle voice: each takes the next voice as a steal
  task automatic fill_held();
    voice_free = 8'h00;
    for (int k = 0; k < 8; k++)
      run_event(1'b1, 8'(60 + k), 8'd90, 1, 3'(k), 1'b1, 8'((1 << (k + 1)) - 1), "fill");
  endtask

  task automatic test_reset();
    ev_if.ev_valid = 1'b0; ev_if.ev_is_on = 1'b0; ev_if.ev_key = '0; ev_if.ev_vel = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ev_if.ev_ready !== 1'b0) $display("FAIL reset ready: got %b want 0", ev_if.ev_ready);
    else passed++;
    total++;
    if ({keys_on, note_on, note_off, steal, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off} !== '0)
      $display("FAIL reset outputs: got %h want 0",
               {keys_on, note_on, note_off, steal, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (ev_if.ev_ready !== 1'b1) $display("FAIL reset release ready: got %b want 1", ev_if.ev_ready);
    else passed++;
  endtask

  task automatic test_first_note();
    voice_free = 8'hFF;
    run_event(1'b1, 8'd60, 8'd100, 1, 3'd0, 1'b0, 8'h01, "first_note");
  endtask

  task automatic test_steal_oldest();
    do_reset();
    fill_held();
    run_event(1'b1, 8'd70, 8'd50, 1, 3'd0, 1'b1, 8'hFF, "steal_oldest");
  endtask

  task automatic test_release_reuse();
    do_reset();
    fill_held();
    run_event(1'b0, 8'd62, 8'd40, 2, 3'd2, 1'b0, 8'hFB, "release");
    run_event(1'b1, 8'd80, 8'd77, 1, 3'd2, 1'b1, 8'hFF, "reuse_releasing");
  endtask

  task automatic test_free_priority();
    do_reset();
    voice_free = 8'h20;
    run_event(1'b1, 8'd40, 8'd64, 1, 3'd5, 1'b0, 8'h20, "free_first");
    run_event(1'b1, 8'd50, 8'd65, 1, 3'd0, 1'b1, 8'h21, "releasing_next");
  endtask

  task automatic test_retrigger();
    do_reset();
    voice_free = 8'hFF;
    run_event(1'b1, 8'd60, 8'd100, 1, 3'd0, 1'b0, 8'h01, "retrig_a");
    run_event(1'b1, 8'd60, 8'd110, 1, 3'd0, 1'b0, 8'h01, "retrig_b");
  endtask

  task automatic test_vel0_and_drop();
    do_reset();
    voice_free = 8'hFF;
    for (int k = 0; k < 4; k++)
      run_event(1'b1, 8'(61 + k), 8'd80, 1, 3'(k), 1'b0, 8'((1 << (k + 1)) - 1), "hold");
    run_event(1'b1, 8'd64, 8'd0, 2, 3'd3, 1'b0, 8'h07, "vel0_off");
    run_event(1'b0, 8'd99, 8'd12, 0, 3'd0, 1'b0, 8'h07, "drop_unheld");
    total++;
    if ({cur_key_adr, cur_key_val, cur_vel_off, keys_on} !== {3'd3, 8'd64, 8'd0, 8'h07})
      $display("FAIL drop hold: got %h want %h", {cur_key_adr, cur_key_val, cur_vel_off, keys_on},
               {3'd3, 8'd64, 8'd0, 8'h07});
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    int n, pulses;
    do_reset();
    voice_free = 8'hFF;
    run_event(1'b1, 8'd60, 8'd100, 1, 3'd0, 1'b0, 8'h01, "pre_abort");
    @(negedge clk);
    ev_if.ev_valid = 1'b1; ev_if.ev_is_on = 1'b1; ev_if.ev_key = 8'd61; ev_if.ev_vel = 8'd90;
    n = 0;
    while (ev_if.ev_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({keys_on, note_on, note_off, ev_if.ev_ready} !== '0)
      $display("FAIL abort state: got %h want 0", {keys_on, note_on, note_off, ev_if.ev_ready});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (ev_if.ev_ready !== 1'b1) $display("FAIL abort ready: got %b want 1", ev_if.ev_ready);
    else passed++;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (note_on || note_off) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL abort pulse: got %0d want 0", pulses); else passed++;
    run_event(1'b1, 8'd62, 8'd5, 1, 3'd0, 1'b0, 8'h01, "post_abort");
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_steal_oldest();
    test_release_reuse();
    test_free_priority();
    test_retrigger();
    test_vel0_and_drop();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
